// File: rtl/div16by8_seq_pkg.sv
// Shared definitions for the sequential divider: default widths and FSM state encoding.
package div16by8_seq_pkg;

  localparam int unsigned DefN = 16;  // dividend / quotient width
  localparam int unsigned DefM = 8;   // divisor / remainder width

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/subNbit.sv
// Ripple-carry subtractor: i_a - i_b computed as i_a + ~i_b + 1; borrow is the inverted carry out.
module subNbit #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  // Bit-serial ripple through the full adders, LSB first.
  always_comb begin
    logic w_c;
    w_c    = 1'b1;
    o_diff = '0;
    for (int i = 0; i < W; i++) begin
      o_diff[i] = i_a[i] ^ ~i_b[i] ^ w_c;
      w_c       = (i_a[i] & ~i_b[i]) | (w_c & (i_a[i] ^ ~i_b[i]));
    end
    o_borrow = ~w_c;
  end

endmodule

// File: rtl/div16by8_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, N cycles per division.
module div16by8_seq
  import div16by8_seq_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned M = DefM
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         dbz
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_q, w_q_d;       // dividend bits shift out the top, quotient bits in the bottom
  logic [M-1:0]    r_rem, w_rem_d;   // partial remainder
  logic [M-1:0]    r_b, w_b_d;       // captured divisor
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_dbz, w_dbz_d;

  logic [M:0]      w_diff;
  logic            w_borrow;
  logic            w_fits;

  subNbit #(
    .W(M + 1)
  ) u_sub (
    .i_a     ({r_rem, r_q[N-1]}),
    .i_b     ({1'b0, r_b}),
    .o_diff  (w_diff),
    .o_borrow(w_borrow)
  );

  // A non-negative trial is always below b, so its top bit is zero; either flag marks a failed trial.
  assign w_fits = ~w_borrow & ~w_diff[M];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    w_state_d = r_state;
    w_q_d     = r_q;
    w_rem_d   = r_rem;
    w_b_d     = r_b;
    w_cnt_d   = r_cnt;
    w_dbz_d   = r_dbz;
    case (r_state)
      StIdle: begin
        if (start) begin
          if (b != '0) begin
            w_q_d     = a;
            w_rem_d   = '0;
            w_b_d     = b;
            w_cnt_d   = '0;
            w_dbz_d   = 1'b0;
            w_state_d = StRun;
          end else begin
            w_q_d     = '1;
            w_rem_d   = '0;
            w_dbz_d   = 1'b1;
            w_state_d = StDone;
          end
        end
      end
      StRun: begin
        w_q_d   = {r_q[N-2:0], w_fits};
        w_rem_d = w_fits ? w_diff[M-1:0] : {r_rem[M-2:0], r_q[N-1]};
        w_cnt_d = r_cnt + CntW'(1);
        if (r_cnt == CntW'(N - 1)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      r_q   <= w_q_d;
      r_rem <= w_rem_d;
      r_b   <= w_b_d;
      r_cnt <= w_cnt_d;
      r_dbz <= w_dbz_d;
    end
  end

  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);
  assign q    = r_q;
  assign r    = r_rem;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_div16by8_seq.sv
// Self-checking bench: behavioural divider model compared every cycle plus directed literal cases.
module tb_div16by8_seq;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy, done, dbz;
  logic [15:0] q;
  logic [7:0]  r;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  div16by8_seq #(
    .N(16),
    .M(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: RUN lasts N cycles after acceptance, DONE one cycle, results from arithmetic.
  int          m_run;
  logic        m_done, m_dbz;
  logic [15:0] m_q, p_q;
  logic [7:0]  m_r, p_r;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_run != 0) begin
      m_run <= m_run - 1;
      if (m_run == 1) begin
        m_done <= 1'b1;
        m_q    <= p_q;
        m_r    <= p_r;
      end
    end else if (start) begin
      if (b == 8'd0) begin
        m_done <= 1'b1;
        m_q    <= 16'hFFFF;
        m_r    <= 8'd0;
        m_dbz  <= 1'b1;
      end else begin
        m_run <= N;
        p_q   <= a / 16'(b);
        p_r   <= 8'(a % 16'(b));
        m_dbz <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model; q/r are only meaningful outside RUN.
  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_busy", 32'(busy), 32'(m_run != 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_excl", 32'(busy & done), 32'd0);
      chk("cyc_dbz", 32'(dbz), 32'(m_dbz));
      if (m_run == 0) begin
        chk("cyc_q", 32'(q), 32'(m_q));
        chk("cyc_r", 32'(r), 32'(m_r));
      end
    end
  end

  // One division from an idle, posedge+2-aligned point; returns aligned the same way.
  task automatic do_div(input logic [15:0] ia, input logic [7:0] ib, input bit disturb,
                        input logic [15:0] eq, input logic [7:0] er, input logic ed,
                        input int elat, input string tag);
    int lat;
    bit bs;
    logic [15:0] gq;
    logic [7:0]  gr;
    logic        gd;
    lat = 0;
    bs  = 1'b0;
    gq  = '0;
    gr  = '0;
    gd  = 1'b0;
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (disturb && k == 5) begin
        start = 1'b1;
        a = ~ia;
        b = ib ^ 8'h5A;
      end else if (disturb && k == 6) begin
        start = 1'b0;
        a = ia + 16'd77;
      end
      @(negedge clk);
      if (busy) bs = 1'b1;
      if (done) begin
        lat = k;
        gq  = q;
        gr  = r;
        gd  = dbz;
        break;
      end
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, 32'(gq), 32'(eq));
    chk({tag, "_r"}, 32'(gr), 32'(er));
    chk({tag, "_dbz"}, 32'(gd), 32'(ed));
    chk({tag, "_busy_seen"}, 32'(bs), 32'(ib != 8'd0));
    @(posedge clk);
    #2;
  endtask

  initial begin
    int nd, t1, t2;
    logic [15:0] ra;
    logic [7:0]  rb;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #2;

    do_div(16'd1000, 8'd7, 1'b0, 16'd142, 8'd6, 1'b0, N + 1, "d1000_7");
    do_div(16'hFFFF, 8'h01, 1'b0, 16'hFFFF, 8'd0, 1'b0, N + 1, "dffff_1");
    do_div(16'hFFFF, 8'hFF, 1'b0, 16'h0101, 8'd0, 1'b0, N + 1, "dffff_ff");
    do_div(16'd5, 8'd9, 1'b0, 16'd0, 8'd5, 1'b0, N + 1, "d5_9");
    do_div(16'd1234, 8'd0, 1'b0, 16'hFFFF, 8'd0, 1'b1, 1, "dbz");
    // Result must survive idle cycles until the next accepted start.
    repeat (3) @(posedge clk);
    #2;
    chk("hold_q", 32'(q), 32'hFFFF);
    chk("hold_dbz", 32'(dbz), 32'd1);
    do_div(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6, 1'b0, N + 1, "ignore_start");

    // Reset mid-RUN: outputs clear at once, no done, then a clean division.
    a = 16'd50000;
    b = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 8) begin
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_r", 32'(r), 32'd0);
        chk("abort_dbz", 32'(dbz), 32'd0);
      end
      if (k == 11) rst = 1'b1;
      @(negedge clk);
      if (done) nd++;
      @(posedge clk);
      #2;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    do_div(16'd200, 8'd3, 1'b0, 16'd66, 8'd2, 1'b0, N + 1, "after_rst");

    // Start held high: back-to-back divisions every N+2 cycles.
    a = 16'd300;
    b = 8'd7;
    start = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else begin
          t2 = cyc;
          break;
        end
      end
    end
    start = 1'b0;
    chk("tput_second_done", 32'(t2 >= 0), 32'd1);
    chk("tput_gap", 32'(t2 - t1), 32'(N + 2));
    @(posedge clk);
    #2;

    // Randomized operands, occasional zero divisor and idle gaps.
    for (int i = 0; i < 50; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #2;
      if (rb == 8'd0)
        do_div(ra, rb, 1'b0, 16'hFFFF, 8'd0, 1'b1, 1, "rand");
      else
        do_div(ra, rb, 1'b0, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0, N + 1, "rand");
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div16by8_seq.md
DIV16BY8_SEQ -- requirements
Module: div16by8_seq

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning dividend and quotient width.
REQ-002 The block SHALL have parameter M, default 8, meaning divisor and remainder width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-006 The block SHALL have port a, input, N, unsigned dividend, captured when start is accepted.
REQ-007 The block SHALL have port b, input, M, unsigned divisor, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1, high while in RUN.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking q, r and dbz valid.
REQ-010 The block SHALL have port q, output, N, unsigned quotient.
REQ-011 The block SHALL have port r, output, M, unsigned remainder.
REQ-012 The block SHALL have port dbz, output, 1, divide-by-zero flag, valid with done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 and b!=0, the block SHALL capture a and b, clear the partial remainder and the iteration counter, clear dbz, and go to RUN.
REQ-015 In IDLE with start=1 and b==0, the block SHALL go directly to DONE with q=all ones, r=0 and dbz=1.
REQ-016 RUN SHALL perform restoring division at one quotient bit per cycle, MSB first, for exactly N cycles.
REQ-017 Each RUN cycle SHALL form the trial value {rem[M-1:0], next dividend bit} - {0, b} at M+1 bits; if it is non-negative, rem becomes the trial value and 1 is shifted into q; otherwise rem shifts in the dividend bit and 0 is shifted into q.
REQ-018 After the Nth RUN cycle, the block SHALL enter DONE with q = a/b and r = a mod b, with no overflow possible.
REQ-019 Latency SHALL be: start sampled at edge E0, busy high from E0, DONE entered at edge E0+N, done high for exactly one cycle after that edge; for b==0, done is high after E0+1.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge, where start is sampled again; this gives back-to-back throughput of one division per N+2 cycles.
REQ-021 start SHALL be ignored in RUN and DONE, and a and b changing during RUN SHALL NOT affect the result.
REQ-022 q, r and dbz SHALL hold their final values from DONE until the next accepted start; q and r values in RUN are intermediate and undefined for consumers.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, with busy=0, done=0, q=0, r=0, dbz=0 and counter=0.
REQ-025 Reset asserted mid-RUN SHALL abort the division with no done pulse; the first start after rst deasserts SHALL begin a fresh division.

Structure
REQ-026 The shared arithmetic package SHALL hold the FSM state encodings (IDLE=0, RUN=1, DONE=2) and the default widths N and M.
REQ-027 The trial subtraction SHALL be one combinational sub-module, subNbit (M+1 bits, outputs difference and borrow), built as the ripple adder with b inverted and carry-in 1.
REQ-028 The iteration counter SHALL be ceil(log2(N+1)) bits wide.

Verification
REQ-029 The bench SHALL apply a=16'd1000, b=8'd7 and require q=142, r=6, dbz=0, with done exactly N+1 cycles after start.
REQ-030 The bench SHALL apply a=16'hFFFF, b=8'h01 and require q=16'hFFFF, r=0; it SHALL then apply a=16'hFFFF, b=8'hFF and require q=16'h0101, r=0.
REQ-031 The bench SHALL apply a=5, b=9 and require q=0, r=5.
REQ-032 The bench SHALL apply a=1234, b=0 and require done one cycle after start, with q=16'hFFFF, r=0, dbz=1, and busy never high.
REQ-033 The bench SHALL pulse start with different operands at cycle 5 of RUN and require that it is ignored and the original result is produced.
REQ-034 The bench SHALL drop rst at cycle 8 of RUN and require that all outputs go to 0 immediately, no done pulse occurs, and the next division, 200/3, returns q=66, r=2.
